// File: rtl/ro_scan_ctrl.sv
// Ring-oscillator thermal sensor scan sequencer: settle, count edges over a window, report.
// Optional continuous re-scan is compiled in with RO_SCAN_CONT_EN (adds the cont port).
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | no ring enabled, waiting for start
// S_SETTLE | ring idx enabled, waiting SETTLE cycles, pulses ignored
// S_COUNT  | ring idx enabled, counting its pulses for WINDOW cycles
// S_REPORT | all rings off, result held on out_* until out_ready
module ro_scan_ctrl #(
   parameter int NUM_RO = 4,
   parameter int IDX_W  = 2,
   parameter int SETTLE = 8,
   parameter int WINDOW = 256,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic [NUM_RO-1:0] ro_en,
   input  logic [NUM_RO-1:0] ro_pulse,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [IDX_W-1:0]  out_idx,
   output logic [CNT_W-1:0]  out_count,
   output logic              out_sat
`ifdef RO_SCAN_CONT_EN
   ,
   input  logic              cont
`endif
);

   localparam int TMR_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
   localparam int TMR_W   = $clog2(TMR_MAX) + 1;
   localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE - 1);
   localparam logic [TMR_W-1:0] WINDOW_LD = TMR_W'(WINDOW - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_RO - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_COUNT,
      S_REPORT
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             sat_q, sat_d;
   logic             ring_on;
   logic             pulse_sel;
   logic             handshake;
   logic             cont_go;

`ifdef RO_SCAN_CONT_EN
   assign cont_go = cont;
`else
   assign cont_go = 1'b0;
`endif

   assign ring_on   = (state_q == S_SETTLE) || (state_q == S_COUNT);
   assign handshake = (state_q == S_REPORT) && out_ready;

   always_comb begin
      ro_en     = '0;
      pulse_sel = 1'b0;
      for (int i = 0; i < NUM_RO; i++) begin
         if (idx_q == IDX_W'(i)) begin
            ro_en[i]  = ring_on;
            pulse_sel = ro_pulse[i];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      tmr_d   = tmr_q;
      count_d = count_q;
      sat_d   = sat_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_SETTLE;
               idx_d   = '0;
               tmr_d   = SETTLE_LD;
            end
         end
         S_SETTLE: begin
            if (tmr_q == '0) begin
               state_d = S_COUNT;
               tmr_d   = WINDOW_LD;
               count_d = '0;
               sat_d   = 1'b0;
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         S_COUNT: begin
            // a pulse arriving with the counter at full scale marks the result saturated
            if (pulse_sel) begin
               if (count_q == CNT_MAX) sat_d = 1'b1;
               else                    count_d = count_q + CNT_W'(1);
            end
            if (tmr_q == '0) state_d = S_REPORT;
            else             tmr_d   = tmr_q - TMR_W'(1);
         end
         S_REPORT: begin
            if (handshake) begin
               if (idx_q != IDX_LAST) begin
                  state_d = S_SETTLE;
                  idx_d   = idx_q + IDX_W'(1);
                  tmr_d   = SETTLE_LD;
               end else if (cont_go) begin
                  state_d = S_SETTLE;
                  idx_d   = '0;
                  tmr_d   = SETTLE_LD;
               end else begin
                  state_d = S_IDLE;
                  idx_d   = '0;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         tmr_q   <= '0;
         count_q <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         tmr_q   <= tmr_d;
         count_q <= count_d;
         sat_q   <= sat_d;
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign out_valid = (state_q == S_REPORT);
   assign out_idx   = idx_q;
   assign out_count = count_q;
   assign out_sat   = sat_q;

endmodule

// File: tb/tb_ro_scan_ctrl.sv
// Directed bench for ro_scan_ctrl: default instance plus a CNT_W=4 instance for saturation.
// Define RO_SCAN_CONT_EN to also exercise the continuous-scan path.
module tb_ro_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       busy;
   logic [3:0] ro_en;
   logic [3:0] ro_pulse;
   logic       out_valid;
   logic       out_ready;
   logic [1:0] out_idx;
   logic [15:0] out_count;
   logic       out_sat;
`ifdef RO_SCAN_CONT_EN
   logic       cont;
`endif

   logic       s_start;
   logic       s_busy;
   logic [3:0] s_ro_en;
   logic [3:0] s_pulse;
   logic       s_valid;
   logic       s_ready;
   logic [1:0] s_idx;
   logic [3:0] s_count;
   logic       s_sat;

   int cyc = 0;
   int n_chk = 0;
   int n_fail = 0;
   int pmode = 0;
   int iso_t0 = 0;
   int t0;
   bit agg_ok;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ro_scan_ctrl u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .busy      (busy),
      .ro_en     (ro_en),
      .ro_pulse  (ro_pulse),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_idx   (out_idx),
      .out_count (out_count),
      .out_sat   (out_sat)
`ifdef RO_SCAN_CONT_EN
      ,
      .cont      (cont)
`endif
   );

   ro_scan_ctrl #(.CNT_W(4)) u_sat (
      .clk       (clk),
      .rst       (rst),
      .start     (s_start),
      .busy      (s_busy),
      .ro_en     (s_ro_en),
      .ro_pulse  (s_pulse),
      .out_valid (s_valid),
      .out_ready (s_ready),
      .out_idx   (s_idx),
      .out_count (s_count),
      .out_sat   (s_sat)
`ifdef RO_SCAN_CONT_EN
      ,
      .cont      (1'b0)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic wait_valid(input bit sel, input int max_cyc);
      int n = 0;
      while (((sel ? s_valid : out_valid) !== 1'b1) && (n < max_cyc)) begin
         @(negedge clk);
         n++;
      end
      if (n >= max_cyc) check("valid_timeout", 32'(sel ? s_valid : out_valid), 1);
   endtask

   // called at a negedge; start is sampled at the next posedge, whose cyc value is returned
   task automatic start_sweep(output int t_start);
      start   = 1'b1;
      t_start = cyc + 1;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      int d, d1;
      ro_pulse = '0;
      forever begin
         @(negedge clk);
         d  = cyc - iso_t0;
         d1 = d - 265;
         case (pmode)
            1: ro_pulse = (cyc % 4 == 0) ? 4'hf : 4'h0;
            2: begin
               ro_pulse[0] = (d >= 0) && (d < 8);
               ro_pulse[1] = ((d1 >= 0) && (d1 <= 8)) || (d1 == 263) || (d1 == 264);
               ro_pulse[2] = 1'b0;
               ro_pulse[3] = cyc[0];
            end
            default: ro_pulse = '0;
         endcase
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      out_ready = 1'b1;
      s_start   = 1'b0;
      s_ready   = 1'b1;
      s_pulse   = '0;
`ifdef RO_SCAN_CONT_EN
      cont      = 1'b0;
`endif
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_ro_en", ro_en, 0);
      check("rst_valid", out_valid, 0);
      check("rst_idx", out_idx, 0);
      check("rst_count", out_count, 0);
      check("rst_sat", out_sat, 0);
      rst = 1'b0;
      @(negedge clk);

      // full sweep, pulses every 4th cycle
      pmode = 1;
      start_sweep(t0);
      check("start_busy", busy, 1);
      check("start_ro_en", ro_en, 4'b0001);
      for (int i = 0; i < 4; i++) begin
         wait_valid(0, 400);
         check("sweep_idx", out_idx, i);
         check("sweep_count", out_count, 64);
         check("sweep_sat", out_sat, 0);
         check("sweep_time", cyc - t0, 264 + 265 * i);
         check("sweep_ro_en_off", ro_en, 0);
         if (i == 3) start = 1'b1;
         @(negedge clk);
      end
      check("end_busy", busy, 0);
      @(negedge clk);
      start = 1'b0;
      check("restart_busy", busy, 1);
      check("restart_ro_en", ro_en, 4'b0001);

      // reset in the middle of ring 2's window
      wait_valid(0, 400);
      @(negedge clk);
      wait_valid(0, 400);
      check("pre_rst_idx", out_idx, 1);
      @(negedge clk);
      repeat (20) @(negedge clk);
      check("mid_count_ro_en", ro_en, 4'b0100);
      rst = 1'b1;
      @(negedge clk);
      check("mrst_busy", busy, 0);
      check("mrst_ro_en", ro_en, 0);
      check("mrst_valid", out_valid, 0);
      check("mrst_idx", out_idx, 0);
      check("mrst_count", out_count, 0);
      check("mrst_sat", out_sat, 0);
      rst = 1'b0;
      @(negedge clk);

      // backpressure on ring 1, with start pulses that must be ignored
      start_sweep(t0);
      wait_valid(0, 400);
      check("bp_first_idx", out_idx, 0);
      @(negedge clk);
      wait_valid(0, 400);
      out_ready = 1'b0;
      check("bp_idx", out_idx, 1);
      check("bp_count", out_count, 64);
      agg_ok = 1'b1;
      for (int k = 0; k < 50; k++) begin
         start = (k % 7 == 0);
         @(negedge clk);
         if (!(out_valid === 1'b1 && out_idx === 2'd1 && out_count === 16'd64 && ro_en === 4'd0))
            agg_ok = 1'b0;
      end
      start = 1'b0;
      check("bp_stall_held", agg_ok, 1);
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_next_ro_en", ro_en, 4'b0100);
      check("bp_next_valid", out_valid, 0);
      wait_valid(0, 400);
      @(negedge clk);
      wait_valid(0, 400);
      check("bp_last_idx", out_idx, 3);
      @(negedge clk);
      agg_ok = 1'b1;
      for (int k = 0; k < 300; k++) begin
         if (busy !== 1'b0) agg_ok = 1'b0;
         @(negedge clk);
      end
      check("no_queued_sweep", agg_ok, 1);

      // isolation and window boundaries
      iso_t0 = cyc + 2;
      pmode  = 2;
      @(negedge clk);
      start_sweep(t0);
      wait_valid(0, 400);
      check("iso_idx0_count", out_count, 0);
      @(negedge clk);
      wait_valid(0, 400);
      check("edge_idx1_count", out_count, 2);
      pmode = 0;
      @(negedge clk);
      wait_valid(0, 400);
      check("iso_idx2_count", out_count, 0);
      @(negedge clk);
      wait_valid(0, 400);
      @(negedge clk);

      // saturation on the narrow-counter instance
      s_pulse = 4'b0001;
      s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      wait_valid(1, 400);
      check("sat_idx0", s_idx, 0);
      check("sat_count0", s_count, 15);
      check("sat_flag0", s_sat, 1);
      @(negedge clk);
      wait_valid(1, 400);
      check("sat_idx1", s_idx, 1);
      check("sat_count1", s_count, 0);
      check("sat_flag1", s_sat, 0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         wait_valid(1, 400);
      end
      @(negedge clk);
      check("sat_end_busy", s_busy, 0);

`ifdef RO_SCAN_CONT_EN
      pmode = 1;
      cont  = 1'b1;
      start_sweep(t0);
      for (int i = 0; i < 4; i++) begin
         wait_valid(0, 400);
         @(negedge clk);
      end
      check("cont_busy", busy, 1);
      check("cont_ro_en", ro_en, 4'b0001);
      check("cont_idx", out_idx, 0);
      cont = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wait_valid(0, 400);
         check("cont_idx_seq", out_idx, i);
         @(negedge clk);
      end
      check("cont_stop_busy", busy, 0);
      pmode = 0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
